// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the multi-digit BCD add sequencer.
//   state_t       - sequencer states (IDLE, ADD, DONE)
//   BCD_MAX       - largest legal BCD digit value
//   BCD_ADJ       - correction added when a binary digit sum leaves BCD range
//   bcd_digit_t   - one packed BCD digit
//   sevseg_decode - digit to active-low gfedcba pattern (bit0 = a), blank if > 9;
//                   only referenced when BCD_SEVSEG_EN is defined
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned BCD_ADJ = 6;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [6:0] sevseg_decode(input bcd_digit_t d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder.
//   a, b  - input digits (may be invalid, > 9)
//   cin   - carry in
//   s     - corrected sum digit
//   cout  - decimal carry out
//   bad   - a or b is not a legal BCD digit
// Invalid digits go through the same add/correct rule, no saturation.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout,
    output logic       bad
);

    logic [4:0] raw;
    logic [4:0] adj;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // The 5-bit wrap of the +6 only touches bit 4, the low nibble is exact.
        if (raw > 5'(BCD_MAX)) begin
            adj  = raw + 5'(BCD_ADJ);
            cout = 1'b1;
        end else begin
            adj  = raw;
            cout = 1'b0;
        end
        s   = adj[3:0];
        bad = (a > 4'(BCD_MAX)) || (b > 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_add_sequencer.sv
// bcd_add_sequencer: multi-digit BCD adder that time-shares one digit adder,
// least-significant digit first, with the carry held in a register.
//   clk, rst  - clock, asynchronous active-high reset
//   start     - request, sampled only in IDLE
//   op_a/op_b - packed BCD operands, digit 0 in bits [3:0]
//   busy      - high while digits are being processed
//   done      - one-cycle pulse when sum/cout/err are valid
//   sum, cout - BCD result, held until the next accepted start
//   err       - some operand digit > 9 (sticky per operation)
//   seg       - (only with BCD_SEVSEG_EN) active-low 7-seg, DIGITS sum groups
//               plus one carry group at the top, registered with done
module bcd_add_sequencer
    import bcd_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned IDX_W  = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   op_a,
    input  logic [4*DIGITS-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
`ifdef BCD_SEVSEG_EN
    ,
    output logic [7*(DIGITS+1)-1:0] seg
`endif
);

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] a_r, b_r;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic                last;

    bcd_digit_t          dig_a, dig_b, dsum;
    logic                dcout, dbad;
    logic [4*DIGITS-1:0] sum_nxt;

    bcd_digit_add u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .s    (dsum),
        .cout (dcout),
        .bad  (dbad)
    );

    assign last = (idx == IDX_W'(DIGITS - 1));

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                dig_a = a_r[4*i +: 4];
                dig_b = b_r[4*i +: 4];
            end
        end
    end

    always_comb begin
        sum_nxt = sum;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sum_nxt[4*i +: 4] = dsum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= op_a;
                        b_r   <= op_b;
                        idx   <= '0;
                        carry <= 1'b0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ADD: begin
                    sum   <= sum_nxt;
                    carry <= dcout;
                    idx   <= idx + IDX_W'(1);
                    if (dbad) begin
                        err <= 1'b1;
                    end
                    // Final carry is captured on the last digit so it is
                    // already valid while done is high.
                    if (last) begin
                        cout <= dcout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BCD_SEVSEG_EN
    logic [7*(DIGITS+1)-1:0] seg_nxt;

    always_comb begin
        seg_nxt = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            seg_nxt[7*i +: 7] = sevseg_decode(sum_nxt[4*i +: 4]);
        end
        seg_nxt[7*DIGITS +: 7] = sevseg_decode({3'b000, dcout});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '1;
        end else if (state == ADD && last) begin
            seg <= seg_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_add_sequencer.sv
module tb_bcd_add_sequencer;
    localparam int unsigned D = 4;
    localparam int unsigned W = 4 * D;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;
`ifdef BCD_SEVSEG_EN
    logic [7*(D+1)-1:0] seg;
`endif

    bcd_add_sequencer #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
`ifdef BCD_SEVSEG_EN
        ,
        .seg   (seg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.c));
                chk("err", 64'(err), 64'(e.e));
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec, input logic ee);
        int n;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        sb_q.push_back('{s: es, c: ec, e: ee});
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("busy_first", 64'(busy), 64'(1));
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(D + 1));
        @(negedge clk);
        chk("sum_held", 64'(sum), 64'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, extra;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
`ifdef BCD_SEVSEG_EN
        chk("rst_seg", 64'(seg), 64'(35'h7_FFFF_FFFF));
`endif
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
        run_op(16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op(16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0);
        run_op(16'h00A0, 16'h0005, 16'h0105, 1'b0, 1'b1);
        run_op(16'h0007, 16'h0000, 16'h0007, 1'b0, 1'b0);
`ifdef BCD_SEVSEG_EN
        chk("seg_0007", 64'(seg),
            64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}));
`endif
        run_op(16'h000F, 16'h000F, 16'h0014, 1'b0, 1'b1);

        // start held high, op_a changed while the first operation runs
        @(negedge clk);
        op_a  = 16'h0123;
        op_b  = 16'h0456;
        start = 1'b1;
        sb_q.push_back('{s: 16'h0579, c: 1'b0, e: 1'b0});
        sb_q.push_back('{s: 16'h5456, c: 1'b0, e: 1'b0});
        d1 = 0;
        d2 = 0;
        extra = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) op_a = 16'h5000;
            if (n == 7) begin
                start = 1'b0;
                op_a  = 16'h9999;
            end
            if (done) begin
                if (n == 5) d1 = 1;
                else if (n == 11) d2 = 1;
                else extra++;
            end
        end
        chk("hold_done1", 64'(d1), 64'(1));
        chk("hold_done2", 64'(d2), 64'(1));
        chk("hold_extra_done", 64'(extra), 64'(0));

        // reset while digit 2 is being processed
        @(negedge clk);
        op_a  = 16'h123A;
        op_b  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_err", 64'(err), 64'(1));
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_sum", 64'(sum), 64'(0));
        chk("midrst_cout", 64'(cout), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_op(16'h5678, 16'h4321, 16'h9999, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
